// File: rtl/fp32_pkg.sv
// FP32 field widths and constants shared by the integer-to-float conversion path.
package fp32_pkg;
    localparam int DATA_WIDTH   = 32;
    localparam int FP32_K_WIDTH = 32;
    localparam int FP32_E_WIDTH = 8;
    localparam int FP32_M_WIDTH = 23;
    localparam int FP32_BIAS    = 127;
    localparam logic [31:0] FP32_ZERO = 32'h0;
endpackage

// File: rtl/INTtoFP32.sv
// Unsigned 32-bit integer to FP32, truncating the bits below the 23-bit mantissa.
module INTtoFP32
    import fp32_pkg::*;
(
    input  logic [FP32_K_WIDTH-1:0] int_i,
    output logic [31:0]             fp32_o
);
    logic [4:0]              msb;
    logic [FP32_K_WIDTH-1:0] aligned;
    logic [FP32_E_WIDTH-1:0] exp_field;

    always_comb begin
        msb = 5'd0;
        for (int i = 0; i < FP32_K_WIDTH; i++) begin
            if (int_i[i]) msb = 5'(i);
        end
        // Put the leading one at bit 31; the mantissa is the 23 bits beneath it.
        aligned   = int_i << (5'd31 - msb);
        exp_field = 8'(FP32_BIAS) + {3'b000, msb};
        if (int_i == '0) begin
            fp32_o = FP32_ZERO;
        end else begin
            fp32_o = {1'b0, exp_field, aligned[30:30-FP32_M_WIDTH+1]};
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search starting at ptr.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_any
);
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int idx;
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!grant_any && req[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_WIDTH'(idx);
            end
        end
        if (grant_any) grant = NUM_REQ'(1) << grant_idx;
    end
endmodule

// File: rtl/int2fp_conv_arbiter.sv
// Round-robin shares one INT-to-FP32 converter among NUM_REQ requesters into a
// single registered output stage that can drain and refill in the same cycle.
module int2fp_conv_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_int,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_fp32,
    output logic [ID_WIDTH-1:0]           out_id,
    output logic                          busy
);
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_fp32_q, out_fp32_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  grant_any;
    logic                  can_accept;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] win_int;
    logic [31:0]           win_fp32;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign win_int = req_int[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    INTtoFP32 u_conv (
        .int_i  (win_int),
        .fp32_o (win_fp32)
    );

    // valid/ready: a beat moves on any rising edge where both are high; the
    // output stage accepts whenever it is empty or being drained this cycle.
    assign can_accept = !out_valid_q || out_ready;
    assign req_ready  = grant & {NUM_REQ{can_accept}};
    assign transfer   = grant_any && can_accept;

    always_comb begin
        out_valid_d = out_valid_q;
        out_fp32_d  = out_fp32_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_fp32_d  = win_fp32;
            out_id_d    = grant_idx;
            rr_ptr_d    = (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_fp32_q  <= fp32_pkg::FP32_ZERO;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_fp32_q  <= out_fp32_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_fp32  = out_fp32_q;
    assign out_id    = out_id_q;
    assign busy      = out_valid_q || (|req_valid);
endmodule

// File: tb/tb_int2fp_conv_arbiter.sv
// Directed-vector bench for int2fp_conv_arbiter with 4 requesters.
module tb_int2fp_conv_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_int;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_fp32;
    logic [IW-1:0]     out_id;
    logic              busy;

    int errors = 0;
    int checks = 0;

    int2fp_conv_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_int   (req_int),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp32  (out_fp32),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_req_proto
        assert property (@(posedge clk) disable iff (rst)
            (req_valid[g] && !req_ready[g]) |=> (req_valid[g] && $stable(req_int[g*DW +: DW])))
            else $error("requester %0d dropped valid or changed data before its transfer", g);
    end

    assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_fp32) && $stable(out_id)))
        else $error("output stage changed while stalled");

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = '0;
        req_int   = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_int   = '0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++;
        if (out_fp32 !== 32'h0) begin errors++; $display("FAIL reset_out_fp32 got=%h exp=00000000", out_fp32); end
        checks++;
        if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id got=%0d exp=0", out_id); end
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++;
        if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got=%0d exp=0", dut.rr_ptr_q); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_conversion();
        logic [31:0] vals[4] = '{32'd1, 32'd2, 32'd3, 32'd0};
        logic [31:0] exps[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h00000000};
        reset_dut();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0001;
            req_int[31:0] = vals[k];
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready[%0d] got=%b exp=0001", k, req_ready); end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d] got=%0b exp=1", k, busy); end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_fp32 !== exps[k] || out_id !== 2'd0) begin
                errors++;
                $display("FAIL basic_out[%0d] got v=%0b fp=%h id=%0d exp v=1 fp=%h id=0", k, out_valid, out_fp32, out_id, exps[k]);
            end
        end
        req_valid = '0;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain got v=%0b busy=%0b exp v=0 busy=0", out_valid, busy);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] vals[3] = '{32'hFFFFFFFF, 32'h01000001, 32'h00800000};
        logic [31:0] exps[3] = '{32'h4F7FFFFF, 32'h4B800000, 32'h4B000000};
        reset_dut();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0010;
            req_int[63:32] = vals[k];
            step();
            checks++;
            if (out_valid !== 1'b1 || out_fp32 !== exps[k] || out_id !== 2'd1) begin
                errors++;
                $display("FAIL boundary[%0d] got v=%0b fp=%h id=%0d exp v=1 fp=%h id=1", k, out_valid, out_fp32, out_id, exps[k]);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_round_robin();
        logic [31:0] exps[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        logic [3:0]  exp_rdy;
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) req_int[i*DW +: DW] = 32'(i + 1);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            exp_rdy = 4'b0001 << (c % 4);
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, exp_rdy); end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(c % 4) || out_fp32 !== exps[c % 4]) begin
                errors++;
                $display("FAIL rr_out[%0d] got v=%0b id=%0d fp=%h exp v=1 id=%0d fp=%h", c, out_valid, out_id, out_fp32, c % 4, exps[c % 4]);
            end
        end
        reset_dut();
    endtask

    task automatic test_backpressure();
        reset_dut();
        for (int i = 0; i < N; i++) req_int[i*DW +: DW] = 32'(i + 1);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_fp32 !== 32'h3F800000 || out_id !== 2'd0 || dut.rr_ptr_q !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%0b fp=%h id=%0d ptr=%0d exp v=1 fp=3f800000 id=0 ptr=1",
                         c, out_valid, out_fp32, out_id, dut.rr_ptr_q);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_fp32 !== 32'h40000000 || out_id !== 2'd1) begin
            errors++;
            $display("FAIL bp_refill got v=%0b fp=%h id=%0d exp v=1 fp=40000000 id=1", out_valid, out_fp32, out_id);
        end
        reset_dut();
    endtask

    task automatic test_pointer_after_grant();
        reset_dut();
        out_ready = 1'b1;
        req_valid = 4'b0010;
        req_int[63:32] = 32'd5;
        step();
        checks++;
        if (dut.rr_ptr_q !== 2'd2) begin errors++; $display("FAIL ptr_setup got=%0d exp=2", dut.rr_ptr_q); end
        req_int[31:0]   = 32'd4;
        req_int[127:96] = 32'd8;
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL ptr_first_ready got=%b exp=1000", req_ready); end
        step();
        checks++;
        if (out_id !== 2'd3 || out_fp32 !== 32'h41000000) begin
            errors++;
            $display("FAIL ptr_first_out got id=%0d fp=%h exp id=3 fp=41000000", out_id, out_fp32);
        end
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL ptr_second_ready got=%b exp=0001", req_ready); end
        step();
        checks++;
        if (out_id !== 2'd0 || out_fp32 !== 32'h40800000) begin
            errors++;
            $display("FAIL ptr_second_out got id=%0d fp=%h exp id=0 fp=40800000", out_id, out_fp32);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_async_reset();
        reset_dut();
        for (int i = 0; i < N; i++) req_int[i*DW +: DW] = 32'(i + 1);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got v=%0b exp=1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL areset_immediate got v=%0b ptr=%0d exp v=0 ptr=0", out_valid, dut.rr_ptr_q);
        end
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_held got v=%0b exp=0", out_valid); end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL areset_first_ready got=%b exp=0001", req_ready); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_fp32 !== 32'h3F800000 || dut.rr_ptr_q !== 2'd1) begin
            errors++;
            $display("FAIL areset_first_out got v=%0b id=%0d fp=%h ptr=%0d exp v=1 id=0 fp=3f800000 ptr=1",
                     out_valid, out_id, out_fp32, dut.rr_ptr_q);
        end
        reset_dut();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_int   = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic_conversion();
        test_boundary();
        test_round_robin();
        test_backpressure();
        test_pointer_after_grant();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/int2fp_conv_arbiter.md
Name: int2fp_conv_arbiter

Overview:
- Shares one INT-to-FP32 converter among NUM_REQ independent requesters using round-robin arbitration and valid/ready handshakes.
- Registers the converted result with the winning requester's ID into a single output stage, which feeds the fp32 max/min datapath.
- Throughput is one conversion per cycle while the consumer keeps out_ready high.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, $clog2(NUM_REQ), width of the requester ID tag.
- DATA_WIDTH, 32, integer input width (unsigned).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester valid.
- req_int  in  NUM_REQ*DATA_WIDTH  packed operands; requester i occupies bits [i*32 +: 32].
- req_ready  out  NUM_REQ  per-requester ready; one-hot or all-zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_fp32  out  32  converted FP32 value.
- out_id  out  ID_WIDTH  index of the requester that produced out_fp32.
- busy  out  1  high when out_valid is high or any req_valid is high.

Behaviour:
- Reset values, asynchronous on rst: out_valid=0, out_fp32=0, out_id=0, rr_ptr=0. req_ready is combinational and is 0 while out_valid=0 and no req_valid is high.
- Accept condition: can_accept = !out_valid || out_ready. The output stage may drain and refill in the same cycle.
- Arbitration:
  - Combinational round-robin. Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first requester with req_valid high wins.
  - req_ready[i] = (winner==i) && can_accept.
- Transfer: a transfer occurs when req_valid[i] && req_ready[i] at a rising clk edge. On that edge:
  - out_fp32 <= conv(req_int[i]).
  - out_id <= i.
  - out_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Pointer and output hold:
  - With no transfer, rr_ptr holds.
  - If out_valid && out_ready and there is no transfer, out_valid <= 0. out_fp32 and out_id hold their stale values.
  - If out_valid && !out_ready, all output registers hold (stall), and every req_ready is 0.
- Latency: 1 cycle from a transfer edge to out_valid. Conversion is purely combinational before the output register.
- Conversion rules (conv):
  - Unsigned input; sign bit is always 0.
  - 0 maps to 0x00000000.
  - For nonzero input, exp = 127 + msb_index.
  - The mantissa is the 23 bits below the MSB.
  - Left-align when msb_index<=23. When msb_index>23, truncate the low bits; no rounding.
- Fairness: a requester that holds req_valid continuously is granted within NUM_REQ transfers.
- Requester protocol:
  - A requester must not drop req_valid or change req_int until its transfer occurs.
  - The arbiter does not check this. Assertions in the bench flag any violation.
- Consumer protocol:
  - While out_valid=1 and out_ready=0, out_fp32 and out_id are stable.
  - out_valid never drops without a handshake.
- Reset mid-operation:
  - A pending, unconsumed result is discarded and out_valid falls immediately.
  - rr_ptr returns to 0.
  - No transfer is recorded on the edge where rst is asserted.
- Single active requester: that requester is granted every cycle while can_accept holds, regardless of rr_ptr.
- All req_valid low: no grant and rr_ptr unchanged.

Decomposition:
- Shared package (fp32_pkg):
  - DATA_WIDTH=32, FP32_K_WIDTH=32, FP32_E_WIDTH=8, FP32_M_WIDTH=23.
  - FP32_BIAS=127.
  - FP32_ZERO=32'h0.
- Sub-modules:
  - Instantiate the existing INTtoFP32 once, on the muxed winning operand.
  - Factor the round-robin priority logic into sub-module rr_arbiter. Its parameter is NUM_REQ. Its ports are req, ptr, grant (one-hot), grant_idx, grant_any.

Test Plan:
- Basic conversion: only req 0 is valid, with req_int=1, then 2, 3, 0. Required out_fp32 sequence is 0x3F800000, 0x40000000, 0x40400000, 0x00000000, all with out_id=0, out_ready=1, and one result per cycle.
- Boundary values: req_int=0xFFFFFFFF gives 0x4F7FFFFF. req_int=0x01000001 gives 0x4B800000 (truncation). req_int=0x00800000 gives 0x4B000000.
- Round-robin: all 4 requesters valid continuously with out_ready=1. out_id cycles 0,1,2,3,0,... Each req_ready pulses once every 4 cycles.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending. out_fp32 and out_id stay stable, req_ready stays 0, and rr_ptr does not advance. Then raise out_ready: drain and refill happen in the same cycle, with no bubble.
- Pointer after grant: rr_ptr=2, and req 0 and req 3 are valid. Req 3 wins. On the next cycle req 0 wins.
- Async reset: assert rst mid-stall while out_valid=1. out_valid falls before the next clk edge. After release, req 0 wins first when all requesters are valid.
